// File: rtl/vga_core_pkg.sv
// ---------------------------------------------------------------------------
// vga_core_pkg
// Shared constants for the VGA display core: default 640x480@60 timing,
// default colours, coordinate/colour widths and the test-pattern bar colour
// helper.
// ---------------------------------------------------------------------------
package vga_core_pkg;

   localparam int RGB_W   = 12;
   localparam int COORD_W = 10;

   // Default timing: 640x480, 25 MHz pixel rate from a 100 MHz system clock.
   localparam int DEF_CLK_DIV  = 4;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   localparam int DEF_NUM_BALLS = 2;
   localparam int DEF_BALL_SIZE = 8;

   localparam logic [RGB_W-1:0] DEF_BG_COLOR   = 12'h000;
   localparam logic [RGB_W-1:0] DEF_BALL_COLOR = 12'hF80;
   localparam logic [RGB_W-1:0] BLANK_COLOR    = 12'h000;

   // Bar k of the test pattern: each RGB channel fully on or off by one bit of k.
   function automatic logic [RGB_W-1:0] bar_color(input logic [2:0] k);
      return {{4{k[2]}}, {4{k[1]}}, {4{k[0]}}};
   endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Pixel-tick divider, horizontal/vertical counters and raster decode.
//
// Ports:
//   CLK100MHZ   in   system clock, rising edge
//   reset       in   synchronous, active-high
//   p_tick      out  one-clock pixel enable (tick counter == CLK_DIV-1)
//   h_cnt       out  horizontal position, 0..H_TOTAL-1
//   v_cnt       out  vertical position, 0..V_TOTAL-1
//   hsync       out  active-low horizontal sync decoded from h_cnt
//   vsync       out  active-low vertical sync decoded from v_cnt
//   video_on    out  counters lie inside the active area
//   frame_start out  registered one-clock pulse when counters wrap to (0,0)
// ---------------------------------------------------------------------------
module vga_timing_gen
   import vga_core_pkg::*;
#(
   parameter int CLK_DIV  = DEF_CLK_DIV,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
) (
   input  logic               CLK100MHZ,
   input  logic               reset,
   output logic               p_tick,
   output logic [COORD_W-1:0] h_cnt,
   output logic [COORD_W-1:0] v_cnt,
   output logic               hsync,
   output logic               vsync,
   output logic               video_on,
   output logic               frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int TICK_W  = $clog2(CLK_DIV);

   localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(CLK_DIV - 1);
   localparam logic [COORD_W-1:0] H_LAST    = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] V_LAST    = COORD_W'(V_TOTAL - 1);
   localparam logic [COORD_W-1:0] H_ACT     = COORD_W'(H_ACTIVE);
   localparam logic [COORD_W-1:0] V_ACT     = COORD_W'(V_ACTIVE);
   localparam logic [COORD_W-1:0] HS_FIRST  = COORD_W'(H_ACTIVE + H_FP);
   localparam logic [COORD_W-1:0] HS_LAST   = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [COORD_W-1:0] VS_FIRST  = COORD_W'(V_ACTIVE + V_FP);
   localparam logic [COORD_W-1:0] VS_LAST   = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [TICK_W-1:0] tick_cnt;
   logic              h_wrap;
   logic              v_wrap;

   assign p_tick = (tick_cnt == TICK_LAST);
   assign h_wrap = (h_cnt == H_LAST);
   assign v_wrap = (v_cnt == V_LAST);

   always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
         tick_cnt    <= '0;
         h_cnt       <= '0;
         v_cnt       <= '0;
         frame_start <= 1'b0;
      end else begin
         // Registered so the pulse coincides with the clock on which the
         // counters first read (0,0).
         frame_start <= p_tick && h_wrap && v_wrap;
         tick_cnt    <= p_tick ? '0 : tick_cnt + TICK_W'(1);
         if (p_tick) begin
            h_cnt <= h_wrap ? '0 : h_cnt + COORD_W'(1);
            if (h_wrap) begin
               v_cnt <= v_wrap ? '0 : v_cnt + COORD_W'(1);
            end
         end
      end
   end

   assign hsync    = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
   assign vsync    = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
   assign video_on = (h_cnt < H_ACT) && (v_cnt < V_ACT);

endmodule

// File: rtl/vga_display_core.sv
// ---------------------------------------------------------------------------
// vga_display_core
// VGA raster generator drawing up to NUM_BALLS square sprites over a flat
// background. Sprite positions arrive through a valid/ready handshake into
// shadow registers and are committed to the active set only at frame start,
// so a frame never shows a half-updated sprite set.
//
// Optional feature: define VGA_DISPLAY_CORE_TESTPATTERN_EN to build an
// 8-bar colour test pattern selected by test_mode. Without it test_mode is
// ignored and no bar logic exists.
//
// Ports:
//   CLK100MHZ   in   system clock, rising edge
//   reset       in   synchronous, active-high
//   pos_x       in   NUM_BALLS x 10-bit X coordinates, ball i at [10i+9:10i]
//   pos_y       in   NUM_BALLS x 10-bit Y coordinates, same packing
//   pos_en      in   per-ball draw enable
//   pos_valid   in   position update offered
//   pos_ready   out  update can be accepted (low while one is pending)
//   test_mode   in   test-pattern select (feature build only)
//   rgb         out  registered RGB444 pixel colour
//   VGA_HS      out  registered active-low horizontal sync
//   VGA_VS      out  registered active-low vertical sync
//   frame_start out  one-clock pulse when the raster wraps to (0,0)
// ---------------------------------------------------------------------------
module vga_display_core
   import vga_core_pkg::*;
#(
   parameter int               CLK_DIV    = DEF_CLK_DIV,
   parameter int               H_ACTIVE   = DEF_H_ACTIVE,
   parameter int               H_FP       = DEF_H_FP,
   parameter int               H_SYNC     = DEF_H_SYNC,
   parameter int               H_BP       = DEF_H_BP,
   parameter int               V_ACTIVE   = DEF_V_ACTIVE,
   parameter int               V_FP       = DEF_V_FP,
   parameter int               V_SYNC     = DEF_V_SYNC,
   parameter int               V_BP       = DEF_V_BP,
   parameter int               NUM_BALLS  = DEF_NUM_BALLS,
   parameter int               BALL_SIZE  = DEF_BALL_SIZE,
   parameter logic [RGB_W-1:0] BG_COLOR   = DEF_BG_COLOR,
   parameter logic [RGB_W-1:0] BALL_COLOR = DEF_BALL_COLOR
) (
   input  logic                           CLK100MHZ,
   input  logic                           reset,
   input  logic [NUM_BALLS*COORD_W-1:0]   pos_x,
   input  logic [NUM_BALLS*COORD_W-1:0]   pos_y,
   input  logic [NUM_BALLS-1:0]           pos_en,
   input  logic                           pos_valid,
   output logic                           pos_ready,
   input  logic                           test_mode,
   output logic [RGB_W-1:0]               rgb,
   output logic                           VGA_HS,
   output logic                           VGA_VS,
   output logic                           frame_start
);

   // Sprite bounds use one extra bit so x+BALL_SIZE-1 never wraps.
   localparam logic [COORD_W:0] SPAN = (COORD_W+1)'(BALL_SIZE - 1);

   logic               p_tick;
   logic [COORD_W-1:0] h_cnt;
   logic [COORD_W-1:0] v_cnt;
   logic               hsync;
   logic               vsync;
   logic               video_on;

   vga_timing_gen #(
      .CLK_DIV  (CLK_DIV),
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_timing (
      .CLK100MHZ   (CLK100MHZ),
      .reset       (reset),
      .p_tick      (p_tick),
      .h_cnt       (h_cnt),
      .v_cnt       (v_cnt),
      .hsync       (hsync),
      .vsync       (vsync),
      .video_on    (video_on),
      .frame_start (frame_start)
   );

   // Shadow (written by the handshake) and active (read by the raster) sets.
   logic [NUM_BALLS*COORD_W-1:0] sh_x;
   logic [NUM_BALLS*COORD_W-1:0] sh_y;
   logic [NUM_BALLS-1:0]         sh_en;
   logic [NUM_BALLS*COORD_W-1:0] act_x;
   logic [NUM_BALLS*COORD_W-1:0] act_y;
   logic [NUM_BALLS-1:0]         act_en;
   logic                         pending;
   logic                         accept;
   logic                         commit;

   assign pos_ready = !pending;
   assign accept    = pos_valid && pos_ready && !reset;
   // An accept on the frame_start clock implies nothing was pending, so the
   // fresh data waits in shadow for the following frame.
   assign commit    = frame_start && pending;

   always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
         pending <= 1'b0;
         sh_en   <= '0;
         act_en  <= '0;
      end else begin
         if (commit) begin
            act_en <= sh_en;
         end
         if (accept) begin
            sh_en   <= pos_en;
            pending <= 1'b1;
         end else if (frame_start) begin
            pending <= 1'b0;
         end
      end
   end

   always_ff @(posedge CLK100MHZ) begin
      if (accept) begin
         sh_x <= pos_x;
         sh_y <= pos_y;
      end
      if (commit) begin
         act_x <= sh_x;
         act_y <= sh_y;
      end
   end

   // ---- stage p0: colour of the pixel addressed by the current counters ----
   logic [COORD_W:0]   hx_p0;
   logic [COORD_W:0]   vy_p0;
   logic [COORD_W:0]   bx_p0;
   logic [COORD_W:0]   by_p0;
   logic               hit_p0;
   logic [RGB_W-1:0]   pix_rgb_p0;

   assign hx_p0 = {1'b0, h_cnt};
   assign vy_p0 = {1'b0, v_cnt};

   always_comb begin
      hit_p0 = 1'b0;
      bx_p0  = '0;
      by_p0  = '0;
      for (int i = 0; i < NUM_BALLS; i++) begin
         bx_p0 = {1'b0, act_x[i*COORD_W +: COORD_W]};
         by_p0 = {1'b0, act_y[i*COORD_W +: COORD_W]};
         if (act_en[i] &&
             (hx_p0 >= bx_p0) && (hx_p0 <= bx_p0 + SPAN) &&
             (vy_p0 >= by_p0) && (vy_p0 <= by_p0 + SPAN)) begin
            hit_p0 = 1'b1;
         end
      end
   end

`ifdef VGA_DISPLAY_CORE_TESTPATTERN_EN
   localparam logic [COORD_W-1:0] BAR_W = COORD_W'(H_ACTIVE / 8);

   logic [COORD_W-1:0] bar_q_p0;
   logic [2:0]         bar_k_p0;

   assign bar_q_p0 = h_cnt / BAR_W;
   assign bar_k_p0 = bar_q_p0[2:0];

   always_comb begin
      pix_rgb_p0 = hit_p0 ? BALL_COLOR : BG_COLOR;
      if (test_mode) begin
         pix_rgb_p0 = bar_color(bar_k_p0);
      end
      if (!video_on) begin
         pix_rgb_p0 = BLANK_COLOR;
      end
   end
`else
   logic unused_test_mode;
   assign unused_test_mode = test_mode;

   always_comb begin
      pix_rgb_p0 = hit_p0 ? BALL_COLOR : BG_COLOR;
      if (!video_on) begin
         pix_rgb_p0 = BLANK_COLOR;
      end
   end
`endif

   // ---- stage p1: output registers, loaded once per pixel tick ----
   logic [RGB_W-1:0] rgb_p1;
   logic             hs_p1;
   logic             vs_p1;

   always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
         rgb_p1 <= '0;
         hs_p1  <= 1'b1;
         vs_p1  <= 1'b1;
      end else if (p_tick) begin
         rgb_p1 <= pix_rgb_p0;
         hs_p1  <= hsync;
         vs_p1  <= vsync;
      end
   end

   assign rgb    = rgb_p1;
   assign VGA_HS = hs_p1;
   assign VGA_VS = vs_p1;

endmodule
